// File: rtl/clock_pkg.sv
// Shared definitions for the clock timekeeping core: mode encoding,
// edit-field one-hot codes, BCD limits and the 2-digit BCD step helpers.
package clock_pkg;

  // Time-setting mode sequence, stepped by the mode key
  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_e;

  // One-hot field indication for the display blinker
  localparam logic [2:0] EDIT_RUN = 3'b000;
  localparam logic [2:0] EDIT_HR  = 3'b100;
  localparam logic [2:0] EDIT_MIN = 3'b010;
  localparam logic [2:0] EDIT_SEC = 3'b001;

  // Packed 2-digit BCD limits
  localparam logic [7:0] BCD_ZERO    = 8'h00;
  localparam logic [7:0] BCD_MAX_MS  = 8'h59;
  localparam logic [7:0] BCD_MAX_H24 = 8'h23;
  localparam logic [7:0] BCD_MAX_H12 = 8'h12;
  localparam logic [7:0] BCD_MIN_H12 = 8'h01;

  // Index of each key in the synchroniser bank
  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int NUM_KEYS = 2;

  // Next value of a packed 2-digit BCD count that wraps from max_val to min_val.
  // Anything at or above max_val folds back to min_val, so a corrupted value
  // can never walk into non-BCD codes.
  function automatic logic [7:0] bcd2_next(input logic [7:0] value,
                                           input logic [7:0] min_val,
                                           input logic [7:0] max_val);
    logic [7:0] nxt;
    if (value >= max_val) begin
      nxt = min_val;
    end else if (value[3:0] >= 4'd9) begin
      nxt = {value[7:4] + 4'd1, 4'd0};
    end else begin
      nxt = {value[7:4], value[3:0] + 4'd1};
    end
    return nxt;
  endfunction

  // Edit one-hot code shown while a given mode is active
  function automatic logic [2:0] edit_of(input mode_e mode);
    logic [2:0] code;
    case (mode)
      MODE_RUN:     code = EDIT_RUN;
      MODE_SET_HR:  code = EDIT_HR;
      MODE_SET_MIN: code = EDIT_MIN;
      MODE_SET_SEC: code = EDIT_SEC;
      default:      code = EDIT_RUN;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed BCD counter with increment, clear-to-minimum and a
// combinational carry-out that flags the max -> min wrap of this increment.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MIN_VAL = 8'h00,
  parameter logic [7:0] MAX_VAL = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_r;

  // Wrap is combinational so the next stage can ripple in the same cycle
  assign wrap  = inc & (value_r >= MAX_VAL);
  assign value = value_r;

  // Count register: clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= RST_VAL;
    end else if (clr) begin
      value_r <= MIN_VAL;
    end else if (inc) begin
      value_r <= bcd2_next(value_r, MIN_VAL, MAX_VAL);
    end else begin
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/clock_time_core.sv
// Timekeeping core of the digital clock: BCD hour/minute/second advanced by
// a 1 Hz enable, with a key-driven mode sequencer for setting the time and a
// one-hot edit indication for the display blinker.
module clock_time_core
  import clock_pkg::*;
#(
  parameter bit H24         = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [2:0] edit,
  output logic       carry_hr
);

  localparam logic [7:0] HOUR_MIN = H24 ? BCD_ZERO    : BCD_MIN_H12;
  localparam logic [7:0] HOUR_MAX = H24 ? BCD_MAX_H24 : BCD_MAX_H12;
  localparam logic [7:0] HOUR_RST = H24 ? BCD_ZERO    : BCD_MAX_H12;

  logic [NUM_KEYS-1:0] key_raw_s;
  logic [NUM_KEYS-1:0] key_pulse_s;
  logic                mode_pulse_s;
  logic                inc_pulse_s;

  mode_e               mode_r;
  logic [2:0]          edit_r;
  logic                carry_hr_r;

  logic                run_s;
  logic                set_hr_s;
  logic                set_min_s;
  logic                set_sec_s;

  logic                sec_inc_s;
  logic                sec_clr_s;
  logic                min_inc_s;
  logic                hour_inc_s;
  logic                sec_wrap_s;
  logic                min_wrap_s;

  logic [7:0]          sec_val_s;
  logic [7:0]          min_val_s;
  logic [7:0]          hour_val_s;

  assign key_raw_s[KEY_MODE] = key_mode;
  assign key_raw_s[KEY_INC]  = key_inc;

  // Each key: metastability chain, then a registered rising-edge pulse
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   pulse_r;

    // Synchronise the key level and emit one pulse per rising edge
    always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
        sync_r  <= '0;
        prev_r  <= 1'b0;
        pulse_r <= 1'b0;
      end else begin
        sync_r  <= {sync_r[SYNC_STAGES-2:0], key_raw_s[g]};
        prev_r  <= sync_r[SYNC_STAGES-1];
        pulse_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
      end
    end

    assign key_pulse_s[g] = pulse_r;
  end

  assign mode_pulse_s = key_pulse_s[KEY_MODE];
  assign inc_pulse_s  = key_pulse_s[KEY_INC];

  // Decode the current mode into per-field qualifiers
  always_comb begin
    run_s     = 1'b0;
    set_hr_s  = 1'b0;
    set_min_s = 1'b0;
    set_sec_s = 1'b0;
    case (mode_r)
      MODE_RUN:     run_s     = 1'b1;
      MODE_SET_HR:  set_hr_s  = 1'b1;
      MODE_SET_MIN: set_min_s = 1'b1;
      MODE_SET_SEC: set_sec_s = 1'b1;
      default:      run_s     = 1'b1;
    endcase
  end

  // Counter enables: ticks ripple through all fields in RUN, while an inc
  // pulse in a SET mode touches only the selected field and never carries
  always_comb begin
    sec_inc_s  = run_s & tick_1hz;
    sec_clr_s  = set_sec_s & inc_pulse_s;
    min_inc_s  = sec_wrap_s | (set_min_s & inc_pulse_s);
    hour_inc_s = (run_s & min_wrap_s) | (set_hr_s & inc_pulse_s);
  end

  bcd2_counter #(
    .MIN_VAL (BCD_ZERO),
    .MAX_VAL (BCD_MAX_MS),
    .RST_VAL (BCD_ZERO)
  ) u_sec (
    .clk   (CP),
    .rst   (CR),
    .inc   (sec_inc_s),
    .clr   (sec_clr_s),
    .value (sec_val_s),
    .wrap  (sec_wrap_s)
  );

  bcd2_counter #(
    .MIN_VAL (BCD_ZERO),
    .MAX_VAL (BCD_MAX_MS),
    .RST_VAL (BCD_ZERO)
  ) u_min (
    .clk   (CP),
    .rst   (CR),
    .inc   (min_inc_s),
    .clr   (1'b0),
    .value (min_val_s),
    .wrap  (min_wrap_s)
  );

  bcd2_counter #(
    .MIN_VAL (HOUR_MIN),
    .MAX_VAL (HOUR_MAX),
    .RST_VAL (HOUR_RST)
  ) u_hour (
    .clk   (CP),
    .rst   (CR),
    .inc   (hour_inc_s),
    .clr   (1'b0),
    .value (hour_val_s),
    .wrap  ()
  );

  // Mode sequencer: inc for this cycle has already been routed by the old
  // mode, so a simultaneous mode pulse steps after the field update
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      mode_r <= MODE_RUN;
      edit_r <= EDIT_RUN;
    end else begin
      case (mode_r)
        MODE_RUN: begin
          if (mode_pulse_s) begin
            mode_r <= MODE_SET_HR;
            edit_r <= EDIT_HR;
          end else begin
            mode_r <= MODE_RUN;
            edit_r <= EDIT_RUN;
          end
        end
        MODE_SET_HR: begin
          if (mode_pulse_s) begin
            mode_r <= MODE_SET_MIN;
            edit_r <= EDIT_MIN;
          end else begin
            mode_r <= MODE_SET_HR;
            edit_r <= EDIT_HR;
          end
        end
        MODE_SET_MIN: begin
          if (mode_pulse_s) begin
            mode_r <= MODE_SET_SEC;
            edit_r <= EDIT_SEC;
          end else begin
            mode_r <= MODE_SET_MIN;
            edit_r <= EDIT_MIN;
          end
        end
        MODE_SET_SEC: begin
          if (mode_pulse_s) begin
            mode_r <= MODE_RUN;
            edit_r <= EDIT_RUN;
          end else begin
            mode_r <= MODE_SET_SEC;
            edit_r <= EDIT_SEC;
          end
        end
        default: begin
          mode_r <= MODE_RUN;
          edit_r <= edit_of(MODE_RUN);
        end
      endcase
    end
  end

  // Hour carry flag, high in the same cycle the wrapped time becomes visible
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      carry_hr_r <= 1'b0;
    end else begin
      carry_hr_r <= run_s & min_wrap_s;
    end
  end

  assign hour     = hour_val_s;
  assign minute   = min_val_s;
  assign second   = sec_val_s;
  assign edit     = edit_r;
  assign carry_hr = carry_hr_r;

endmodule
